min_priority_arbiter: RTL and testbench

- Shares one resource among four requesters; each request carries a 3-bit priority, and the lowest value wins.
- Ties on the minimum value are broken round-robin.
- The grant is held until the owner drops its request, or until a hold timeout expires.
- Sits in front of any shared unit in the assignment designs and reuses the minimum-index comparison as its arbitration core.

---
 rtl/min_priority_arbiter_pkg.sv | 18 +
 rtl/min_priority_arbiter_if.sv | 25 ++
 rtl/min_priority_arbiter_masked_min4.sv | 37 +++
 rtl/min_priority_arbiter.sv | 132 +++++++++++++
 tb/tb_min_priority_arbiter.sv | 219 +++++++++++++++++++++
 5 files changed

// File: rtl/min_priority_arbiter_pkg.sv
// Shared types and constants for min_priority_arbiter.
package arb_pkg;
  localparam int NREQ = 4;
  localparam int IDXW = 2;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_e;

  // One-hot vector with bit idx set.
  function automatic logic [NREQ-1:0] onehot(input logic [IDXW-1:0] idx);
    logic [NREQ-1:0] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction
endpackage

// File: rtl/min_priority_arbiter_if.sv
// Request/grant bundle between requesters (master) and the arbiter (slave).
interface min_priority_arbiter_if
  import arb_pkg::*;
#(
  parameter int PW = 3
);
  logic [NREQ-1:0] req;
  logic [PW-1:0]   prio0;
  logic [PW-1:0]   prio1;
  logic [PW-1:0]   prio2;
  logic [PW-1:0]   prio3;
  logic [NREQ-1:0] gnt;
  logic [IDXW-1:0] gnt_idx;
  logic            busy;

  modport master (
    output req, prio0, prio1, prio2, prio3,
    input  gnt, gnt_idx, busy
  );

  modport slave (
    input  req, prio0, prio1, prio2, prio3,
    output gnt, gnt_idx, busy
  );
endinterface

// File: rtl/min_priority_arbiter_masked_min4.sv
// masked_min4: combinational minimum search over four requesters.
// Ineligible entries get their key MSB set so they lose to any eligible one;
// equal minima resolve to the first index after rr_ptr (rotating order).
module masked_min4
  import arb_pkg::*;
#(
  parameter int PW = 3
) (
  input  logic [NREQ-1:0][PW-1:0] prio,
  input  logic [NREQ-1:0]         elig,
  input  logic [IDXW-1:0]         rr_ptr,
  output logic [IDXW-1:0]         win_idx
);
  localparam int KW = PW + 1;

  logic [NREQ-1:0][KW-1:0] mkey;
  logic [KW-1:0]           best_key;
  logic [IDXW-1:0]         cand;

  for (genvar i = 0; i < NREQ; i++) begin : g_key
    assign mkey[i] = {~elig[i], prio[i]};
  end

  // Scan rr_ptr+1 .. rr_ptr+4 (mod 4); strict compare keeps the earliest tie.
  always_comb begin
    win_idx  = rr_ptr + IDXW'(1);
    best_key = mkey[win_idx];
    cand     = win_idx;
    for (int k = 2; k <= NREQ; k++) begin
      cand = rr_ptr + IDXW'(k);
      if (mkey[cand] < best_key) begin
        best_key = mkey[cand];
        win_idx  = cand;
      end
    end
  end
endmodule

// File: rtl/min_priority_arbiter.sv
// min_priority_arbiter: four requesters, lowest priority value wins, ties
// round-robin, grant held until the owner drops its request.
// Optional macro ARB_TIMEOUT_EN adds a hold timeout of HOLD_MAX cycles; a
// timed-out owner is excluded from the next arbitration if anyone else waits.
module min_priority_arbiter
  import arb_pkg::*;
#(
  parameter int PW = 3
`ifdef ARB_TIMEOUT_EN
  , parameter int HOLD_MAX = 15
`endif
) (
  input logic                  clk,
  input logic                  rst_n,
  min_priority_arbiter_if.slave bus
);
  state_e          state_q, state_d;
  logic [NREQ-1:0] gnt_q, gnt_d;
  logic [IDXW-1:0] gnt_idx_q, gnt_idx_d;
  logic            busy_q, busy_d;
  logic [IDXW-1:0] rr_ptr_q, rr_ptr_d;
`ifdef ARB_TIMEOUT_EN
  localparam logic [7:0] HOLD_LAST = 8'(HOLD_MAX - 1);
  logic [7:0]      hold_cnt_q, hold_cnt_d;
  logic [NREQ-1:0] excl_q, excl_d;
`endif

  logic [NREQ-1:0][PW-1:0] prio_v;
  logic [NREQ-1:0]         elig;
  logic [IDXW-1:0]         win_idx;

  assign prio_v[0] = bus.prio0;
  assign prio_v[1] = bus.prio1;
  assign prio_v[2] = bus.prio2;
  assign prio_v[3] = bus.prio3;
`ifdef ARB_TIMEOUT_EN
  assign elig = bus.req & ~excl_q;
`else
  assign elig = bus.req;
`endif

  masked_min4 #(.PW(PW)) u_min (
    .prio    (prio_v),
    .elig    (elig),
    .rr_ptr  (rr_ptr_q),
    .win_idx (win_idx)
  );

  // Next-state: arbitrate in IDLE, hold/release (or time out) in GRANT.
  always_comb begin
    state_d   = state_q;
    gnt_d     = gnt_q;
    gnt_idx_d = gnt_idx_q;
    busy_d    = busy_q;
    rr_ptr_d  = rr_ptr_q;
`ifdef ARB_TIMEOUT_EN
    hold_cnt_d = hold_cnt_q;
    excl_d     = excl_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (|elig) begin
          state_d   = GRANT;
          gnt_d     = onehot(win_idx);
          gnt_idx_d = win_idx;
          busy_d    = 1'b1;
          rr_ptr_d  = win_idx;
`ifdef ARB_TIMEOUT_EN
          hold_cnt_d = '0;
          excl_d     = '0;
`endif
        end else begin
          gnt_d     = '0;
          gnt_idx_d = '0;
          busy_d    = 1'b0;
        end
      end
      GRANT: begin
`ifdef ARB_TIMEOUT_EN
        hold_cnt_d = hold_cnt_q + 8'd1;
`endif
        // Release wins over timeout when both happen together.
        if (!bus.req[gnt_idx_q]) begin
          state_d   = IDLE;
          gnt_d     = '0;
          gnt_idx_d = '0;
          busy_d    = 1'b0;
        end
`ifdef ARB_TIMEOUT_EN
        else if (hold_cnt_q == HOLD_LAST) begin
          state_d   = IDLE;
          gnt_d     = '0;
          gnt_idx_d = '0;
          busy_d    = 1'b0;
          // Only bar the owner if someone else is actually waiting.
          if (|(bus.req & ~gnt_q)) excl_d = gnt_q;
        end
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers; reset acts immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      gnt_q     <= '0;
      gnt_idx_q <= '0;
      busy_q    <= 1'b0;
      rr_ptr_q  <= IDXW'(NREQ - 1);
`ifdef ARB_TIMEOUT_EN
      hold_cnt_q <= '0;
      excl_q     <= '0;
`endif
    end else begin
      state_q   <= state_d;
      gnt_q     <= gnt_d;
      gnt_idx_q <= gnt_idx_d;
      busy_q    <= busy_d;
      rr_ptr_q  <= rr_ptr_d;
`ifdef ARB_TIMEOUT_EN
      hold_cnt_q <= hold_cnt_d;
      excl_q     <= excl_d;
`endif
    end
  end

  assign bus.gnt     = gnt_q;
  assign bus.gnt_idx = gnt_idx_q;
  assign bus.busy    = busy_q;
endmodule

// File: tb/tb_min_priority_arbiter.sv
// Bench for min_priority_arbiter: directed scenarios plus random traffic
// checked against a cycle-level behavioural model of the arbitration rules.
module tb_min_priority_arbiter;
  localparam int HOLD = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_cmp = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  min_priority_arbiter_if #(.PW(3)) bus ();

`ifdef ARB_TIMEOUT_EN
  min_priority_arbiter #(.PW(3), .HOLD_MAX(HOLD)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
`else
  min_priority_arbiter #(.PW(3)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
`endif

  // ---------------- reference model ----------------
  logic       m_busy;
  int         m_owner, m_rr, m_held;
  logic [3:0] m_excl;

  // Winner: scan rr+1..rr+4, keep strictly smaller priority among eligible.
  function automatic int pick(input logic [3:0] r, input logic [3:0] ex, input int rr,
                              input logic [2:0] p0, input logic [2:0] p1,
                              input logic [2:0] p2, input logic [2:0] p3);
    int best, i;
    int pr[4];
    pr[0] = p0; pr[1] = p1; pr[2] = p2; pr[3] = p3;
    best = -1;
    for (int k = 1; k <= 4; k++) begin
      i = (rr + k) % 4;
      if (r[i] && !ex[i] && (best < 0 || pr[i] < pr[best])) best = i;
    end
    return best;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy <= 1'b0; m_owner <= 0; m_rr <= 3; m_held <= 0; m_excl <= 4'b0000;
    end else if (!m_busy) begin
      if (pick(bus.req, m_excl, m_rr, bus.prio0, bus.prio1, bus.prio2, bus.prio3) >= 0) begin
        m_busy  <= 1'b1;
        m_owner <= pick(bus.req, m_excl, m_rr, bus.prio0, bus.prio1, bus.prio2, bus.prio3);
        m_rr    <= pick(bus.req, m_excl, m_rr, bus.prio0, bus.prio1, bus.prio2, bus.prio3);
        m_held  <= 1;
        m_excl  <= 4'b0000;
      end
    end else if (!bus.req[m_owner]) begin
      m_busy <= 1'b0;
    end
`ifdef ARB_TIMEOUT_EN
    else if (m_held == HOLD) begin
      m_busy <= 1'b0;
      m_excl <= ((bus.req & ~(4'b0001 << m_owner)) != 4'b0000) ? (4'b0001 << m_owner) : 4'b0000;
    end
`endif
    else begin
      m_held <= m_held + 1;
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic drive(input logic [3:0] r, input logic [2:0] p0, input logic [2:0] p1,
                       input logic [2:0] p2, input logic [2:0] p3);
    bus.req = r; bus.prio0 = p0; bus.prio1 = p1; bus.prio2 = p2; bus.prio3 = p3;
  endtask

  task automatic go_idle();
    bus.req = 4'b0000;
    repeat (2) @(negedge clk);
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    #1;
    n_cmp++; if (bus.gnt !== 4'b0000) begin n_fail++; $display("FAIL reset_gnt: got %b want 0000", bus.gnt); end
    n_cmp++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
    n_cmp++; if (bus.gnt_idx !== 2'b00) begin n_fail++; $display("FAIL reset_idx: got %b want 00", bus.gnt_idx); end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_rr_tie();
    int order[5] = '{0, 1, 2, 3, 0};
    logic [3:0] want;
    drive(4'b1111, 3'd3, 3'd3, 3'd3, 3'd3);
    for (int n = 0; n < 5; n++) begin
      want = 4'b0001 << order[n];
      @(negedge clk);
      n_cmp++; if (bus.gnt !== want) begin n_fail++; $display("FAIL rr_grant%0d: got %b want %b", n, bus.gnt, want); end
      @(negedge clk);
      n_cmp++; if (bus.gnt !== want) begin n_fail++; $display("FAIL rr_hold%0d: got %b want %b", n, bus.gnt, want); end
      bus.req[order[n]] = 1'b0;
      @(negedge clk);
      n_cmp++; if (bus.gnt !== 4'b0000) begin n_fail++; $display("FAIL rr_gap%0d: got %b want 0000", n, bus.gnt); end
      bus.req = 4'b1111;
    end
    go_idle();
  endtask

  task automatic test_single();
    drive(4'b0100, 3'd1, 3'd0, 3'd5, 3'd2);
    @(negedge clk);
    n_cmp++; if (bus.gnt !== 4'b0100) begin n_fail++; $display("FAIL single_gnt: got %b want 0100", bus.gnt); end
    n_cmp++; if (bus.gnt_idx !== 2'd2) begin n_fail++; $display("FAIL single_idx: got %0d want 2", bus.gnt_idx); end
    n_cmp++; if (bus.busy !== 1'b1) begin n_fail++; $display("FAIL single_busy: got %b want 1", bus.busy); end
    bus.req = 4'b0000;
    @(negedge clk);
    n_cmp++; if (bus.gnt !== 4'b0000) begin n_fail++; $display("FAIL single_rel: got %b want 0000", bus.gnt); end
    n_cmp++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL single_relbusy: got %b want 0", bus.busy); end
    @(negedge clk);
  endtask

  task automatic test_priority();
    drive(4'b1111, 3'd6, 3'd2, 3'd1, 3'd7);
    @(negedge clk);
    n_cmp++; if (bus.gnt !== 4'b0100) begin n_fail++; $display("FAIL prio_win: got %b want 0100", bus.gnt); end
    bus.req = 4'b1011;
    @(negedge clk);
    n_cmp++; if (bus.gnt !== 4'b0000) begin n_fail++; $display("FAIL prio_gap: got %b want 0000", bus.gnt); end
    @(negedge clk);
    n_cmp++; if (bus.gnt !== 4'b0010) begin n_fail++; $display("FAIL prio_next: got %b want 0010", bus.gnt); end
    go_idle();
  endtask

`ifdef ARB_TIMEOUT_EN
  task automatic test_timeout();
    drive(4'b0011, 3'd0, 3'd5, 3'd0, 3'd0);
    for (int c = 0; c < HOLD; c++) begin
      @(negedge clk);
      n_cmp++; if (bus.gnt !== 4'b0001) begin n_fail++; $display("FAIL tmo_hold%0d: got %b want 0001", c, bus.gnt); end
    end
    @(negedge clk);
    n_cmp++; if (bus.gnt !== 4'b0000) begin n_fail++; $display("FAIL tmo_gap: got %b want 0000", bus.gnt); end
    @(negedge clk);
    n_cmp++; if (bus.gnt !== 4'b0010) begin n_fail++; $display("FAIL tmo_excl: got %b want 0010", bus.gnt); end
    go_idle();
  endtask
`else
  task automatic test_no_timeout();
    drive(4'b0011, 3'd0, 3'd5, 3'd0, 3'd0);
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      n_cmp++; if (bus.gnt !== 4'b0001) begin n_fail++; $display("FAIL hold%0d: got %b want 0001", c, bus.gnt); end
    end
    go_idle();
  endtask
`endif

  task automatic test_async_reset();
    drive(4'b1000, 3'd0, 3'd0, 3'd0, 3'd2);
    @(negedge clk);
    n_cmp++; if (bus.gnt !== 4'b1000) begin n_fail++; $display("FAIL ar_pre: got %b want 1000", bus.gnt); end
    #1 rst_n = 1'b0;
    #1;
    n_cmp++; if (bus.gnt !== 4'b0000) begin n_fail++; $display("FAIL ar_gnt: got %b want 0000", bus.gnt); end
    n_cmp++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL ar_busy: got %b want 0", bus.busy); end
    n_cmp++; if (bus.gnt_idx !== 2'b00) begin n_fail++; $display("FAIL ar_idx: got %b want 00", bus.gnt_idx); end
    drive(4'b1111, 3'd4, 3'd4, 3'd4, 3'd4);
    #1 rst_n = 1'b1;
    @(negedge clk);
    n_cmp++; if (bus.gnt !== 4'b0001) begin n_fail++; $display("FAIL ar_first: got %b want 0001", bus.gnt); end
    go_idle();
  endtask

  task automatic test_masking();
    drive(4'b0010, 3'd0, 3'd7, 3'd0, 3'd0);
    @(negedge clk);
    n_cmp++; if (bus.gnt !== 4'b0010) begin n_fail++; $display("FAIL mask_gnt: got %b want 0010", bus.gnt); end
    n_cmp++; if (bus.gnt_idx !== 2'd1) begin n_fail++; $display("FAIL mask_idx: got %0d want 1", bus.gnt_idx); end
    go_idle();
  endtask

  task automatic test_random();
    logic [3:0] want, prev;
    prev = bus.gnt;
    for (int c = 0; c < 1500; c++) begin
      @(negedge clk);
      want = m_busy ? (4'b0001 << m_owner) : 4'b0000;
      n_cmp++; if (bus.gnt !== want) begin n_fail++; $display("FAIL rnd_gnt@%0d: got %b want %b", c, bus.gnt, want); end
      n_cmp++; if (bus.busy !== m_busy) begin n_fail++; $display("FAIL rnd_busy@%0d: got %b want %b", c, bus.busy, m_busy); end
      if (m_busy) begin
        n_cmp++; if (bus.gnt_idx !== 2'(m_owner)) begin n_fail++; $display("FAIL rnd_idx@%0d: got %0d want %0d", c, bus.gnt_idx, m_owner); end
      end
      n_cmp++; if (!$onehot0(bus.gnt)) begin n_fail++; $display("FAIL rnd_onehot@%0d: got %b", c, bus.gnt); end
      if (prev != 4'b0000 && bus.gnt != 4'b0000) begin
        n_cmp++; if (bus.gnt !== prev) begin n_fail++; $display("FAIL rnd_gap@%0d: got %b after %b", c, bus.gnt, prev); end
      end
      prev = bus.gnt;
      for (int i = 0; i < 4; i++) if ($urandom_range(3) == 0) bus.req[i] = ~bus.req[i];
      bus.prio0 = 3'($urandom); bus.prio1 = 3'($urandom);
      bus.prio2 = 3'($urandom); bus.prio3 = 3'($urandom);
    end
    go_idle();
  endtask

  initial begin
    drive(4'b0000, 3'd0, 3'd0, 3'd0, 3'd0);
    test_reset();
    test_rr_tie();
    test_single();
    test_priority();
`ifdef ARB_TIMEOUT_EN
    test_timeout();
`else
    test_no_timeout();
`endif
    test_async_reset();
    test_masking();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
